// File: rtl/adder_3bit_rr_ctrl.sv
// Round-robin arbiter that time-shares one 3-bit adder among NREQ requesters.
// Each operation takes IDLE -> CALC -> DONE and returns a registered result with a done pulse.

module adder_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [2:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// Handshake: req is a level held by the requester; gnt marks the operation in flight,
// and done pulses for one cycle with gnt. Requesters drop req within a cycle of done.
module adder_3bit_rr_ctrl #(
  parameter int NREQ = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [3*NREQ-1:0]   a_in,
  input  logic [3*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [2:0]          sum_out,
  output logic                carry_out,
  output logic                busy
);
  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_q;
  logic [PW-1:0]   win;
  logic            found;
  logic [2:0]      op_a;
  logic [2:0]      op_b;
  logic [2:0]      win_a;
  logic [2:0]      win_b;
  logic [2:0]      add_sum;
  logic            add_carry;

  // Search upward from ptr, wrapping, for the first active request.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign win_a = a_in[3*int'(win) +: 3];
  assign win_b = b_in[3*int'(win) +: 3];
  assign busy  = (state != IDLE);

  adder_3bit u_adder (
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      win_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      done      <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= ONE << win;
            win_q <= win;
            op_a  <= win_a;
            op_b  <= win_b;
            state <= CALC;
          end
        end
        CALC: begin
          sum_out   <= add_sum;
          carry_out <= add_carry;
          done      <= gnt;
          state     <= DONE;
        end
        DONE: begin
          done  <= '0;
          gnt   <= '0;
          // The winner moves to the back of the queue.
          ptr   <= (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_3bit_rr_ctrl.sv
// Directed bench for adder_3bit_rr_ctrl (NREQ=3): grant order, latency, arithmetic, reset abort.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_adder_3bit_rr_ctrl;
  localparam int NREQ = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] a_in;
  logic [3*NREQ-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2:0]        sum_out;
  logic              carry_out;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  adder_3bit_rr_ctrl #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .done      (done),
    .sum_out   (sum_out),
    .carry_out (carry_out),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int i, input logic [2:0] a, input logic [2:0] b);
    a_in[3*i +: 3] = a;
    b_in[3*i +: 3] = b;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt0"}, 32'(gnt), 32'd0);
    check({tag, "_done0"}, 32'(done), 32'd0);
    check({tag, "_busy0"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] held;
    logic [2:0] fair_gnt[4];
    fair_gnt[0] = 3'b001; fair_gnt[1] = 3'b100; fair_gnt[2] = 3'b001; fair_gnt[3] = 3'b100;

    rst_n = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;

    // Single request: 3 + 5 = 8 -> carry 1, sum 000
    set_ops(0, 3'd3, 3'd5);
    req = 3'b001;
    step();
    check("single_gnt", 32'(gnt), 32'b001);
    check("single_busy", 32'(busy), 32'd1);
    check("single_nodone", 32'(done), 32'd0);
    req = 3'b000;
    step();
    check("single_done", 32'(done), 32'b001);
    check("single_gnt_hold", 32'(gnt), 32'b001);
    check("single_res", 32'({carry_out, sum_out}), 32'h8);
    step();
    check_idle("single_end");

    // All three from reset: 1+2=3, 4+6=10, 7+5=12
    do_reset();
    set_ops(0, 3'd1, 3'd2);
    set_ops(1, 3'd4, 3'd6);
    set_ops(2, 3'd7, 3'd5);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd10);
    exp_q.push_back(4'd12);
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      step();
      check("all_gnt", 32'(gnt), 32'(3'b001 << k));
      step();
      check("all_done", 32'(done), 32'(3'b001 << k));
      r = exp_q.pop_front();
      check("all_res", 32'({carry_out, sum_out}), 32'(r));
      step();
      check_idle("all_gap");
      if (k == 2) req = 3'b000;
    end

    // Fairness: req0 held, req2 joins during the first op; ptr is 0 here
    set_ops(0, 3'd2, 3'd2);
    set_ops(2, 3'd1, 3'd1);
    req = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fair_gnt", 32'(gnt), 32'(fair_gnt[k]));
      req = 3'b101;
      step();
      check("fair_done", 32'(done), 32'(fair_gnt[k]));
      check("fair_res", 32'({carry_out, sum_out}), (k % 2 == 0) ? 32'd4 : 32'd2);
      step();
      if (k == 3) req = 3'b000;
    end
    check_idle("fair_end");

    // Exhaustive arithmetic through requester 1 (ptr back at 0, only req1 active)
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        set_ops(1, 3'(a), 3'(b));
        req = 3'b010;
        step();
        check("exh_gnt", 32'(gnt), 32'b010);
        req = 3'b000;
        step();
        check("exh_res", 32'({carry_out, sum_out}), 32'(a + b));
        held = {carry_out, sum_out};
        set_ops(1, 3'(7 - a), 3'(b ^ 5));
        step();
        check("exh_hold", 32'({carry_out, sum_out}), 32'(a + b));
        check("exh_busy", 32'(busy), 32'd0);
      end
    end

    // Mid-operation changes: 6 + 3 = 9 latched, then operands and req change
    set_ops(0, 3'd6, 3'd3);
    req = 3'b001;
    step();
    check("mid_gnt", 32'(gnt), 32'b001);
    req = 3'b000;
    set_ops(0, 3'd0, 3'd0);
    step();
    check("mid_done", 32'(done), 32'b001);
    check("mid_res", 32'({carry_out, sum_out}), 32'd9);
    step();
    check_idle("mid_end");

    // Reset during CALC aborts the op
    set_ops(2, 3'd5, 3'd5);
    set_ops(1, 3'd2, 3'd3);
    req = 3'b100;
    step();
    check("rc_gnt", 32'(gnt), 32'b100);
    req = 3'b000;
    rst_n = 1'b0;
    #1;
    check("rc_gnt0", 32'(gnt), 32'd0);
    check("rc_done0", 32'(done), 32'd0);
    check("rc_busy0", 32'(busy), 32'd0);
    check("rc_res0", 32'({carry_out, sum_out}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rc_nodone", 32'(done), 32'd0);
    end
    req = 3'b110;
    step();
    check("rc_regnt", 32'(gnt), 32'b010);
    req = 3'b000;
    step();
    check("rc_redone", 32'(done), 32'b010);
    check("rc_reres", 32'({carry_out, sum_out}), 32'd5);
    step();
    check_idle("rc_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_3bit_rr_ctrl.md
# adder_3bit_rr_ctrl

Round-robin controller that shares one `adder_3bit` instance among `NREQ` requesters. Each requester presents a pair of 3-bit operands with a level request. The controller grants one requester at a time, latches that requester's operands, and drives the shared adder. It then returns the registered `{carry, sum}` result with a one-cycle done pulse to the granted requester. It sits between the L4 client blocks and the single `adder_3bit` datapath, and the `adder_3bit` instance lives inside this block.

## Interface
- `NREQ`, default 3: number of requesters, legal range 2..8.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  `NREQ`: level request; bit i belongs to requester i.
- `a_in`  in  `3*NREQ`: packed operand A; requester i uses bits `[3*i+2:3*i]`.
- `b_in`  in  `3*NREQ`: packed operand B, packed the same way as `a_in`.
- `gnt`  out  `NREQ`: one-hot grant, registered.
- `done`  out  `NREQ`: one-hot, one-cycle result-valid pulse to the granted requester, registered.
- `sum_out`  out  3: registered adder sum.
- `carry_out`  out  1: registered adder carry.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE behaviour:
  - If `req` is 0, stay in IDLE.
  - Otherwise pick the winner: the first set `req` bit searching upward from `ptr` and wrapping modulo `NREQ`.
  - Set `gnt` to the one-hot winner.
  - Latch the winner's operands into `op_a`/`op_b`.
  - Move to CALC.
- CALC behaviour:
  - The shared `adder_3bit` sees `op_a`/`op_b`.
  - On the exit edge: `sum_out`/`carry_out` take the adder result, `done` takes `gnt`, and the state moves to DONE.
- DONE behaviour:
  - `done` is high for exactly this cycle.
  - On the exit edge: clear `done` and `gnt`, set `ptr` to (winner+1) mod `NREQ`, and return to IDLE.
- Arithmetic: `{carry_out, sum_out}` = `op_a` + `op_b`, unsigned, result range 0..14. Example: 7+7 gives carry 1, sum 110.
- `sum_out`/`carry_out` hold their value until the next DONE entry.
- `ptr` (clog2 width) resets to 0 and changes only on DONE exit.
- Operands are sampled only on the IDLE→CALC edge. Later changes to `a_in`/`b_in`, or dropping `req`, do not affect the operation in flight; it always completes.
- A `req` dropped before it is granted is never serviced.
- If a requester still has `req` high when the FSM returns to IDLE, that is a new request. It ranks after the others because `ptr` has moved past it.
- Non-granted requesters may change their `req` bits freely.

## Timing
- Reset (async assert, synchronous-to-clk release via flop reset):
  - `gnt` = 0, `done` = 0, `sum_out` = 0, `carry_out` = 0, `busy` = 0, `ptr` = 0, state = IDLE.
- Reset mid-operation aborts immediately: no `done` pulse is produced and the operands are discarded.
- Latency, with the request sampled at edge E0:
  - After E0: `gnt` and `busy` are high.
  - After E1: `done` is high and the result is valid.
  - After E2: `gnt`, `done` and `busy` are low.
- The earliest next grant is edge E3, so throughput is one operation per 3 cycles.
- Simultaneous requests are resolved purely by `ptr`; there is no fixed priority.
- `gnt` and `done` are never high for more than one bit.
- `done` is high only while `gnt` holds the same bit.
- Requesters must drop `req` within one cycle of seeing `done` if they do not want another operation.

## Test plan
- **Single request:** after reset, `req`=001, `a0`=3, `b0`=5.
  - `gnt`=001 after E0; `done`=001 for one cycle after E1.
  - Result: `sum_out`=000, `carry_out`=1; `busy` low after E2.
- **All three requesting from reset:** `req`=111 held, each requester with distinct operands.
  - Service order is 0, 1, 2, with `done` pulses at E1, E4 and E7.
  - Each result matches its own requester's operands.
- **Fairness:** requester 0 holds `req` permanently; requester 2 asserts `req` during the first operation.
  - Grant order is 0, 2, 0, 2, …; requester 1 is never granted.
- **Exhaustive arithmetic:** all 64 (a, b) pairs through requester 1.
  - Every pair gives `{carry_out, sum_out}` = a+b.
  - Outputs hold between operations.
- **Mid-operation changes:** after the grant, drop `req` and change `a_in`/`b_in`.
  - `done` is still pulsed and the result uses the originally latched operands.
- **Reset in CALC:** pull `rst_n` low.
  - All outputs go to 0 immediately.
  - After release with `req`=0, no `done` ever appears; with `req`=110, requester 1 is granted first (`ptr`=0).
